// File: rtl/core_pkg.sv
// Definitions shared by the execute and writeback stages: load/store widths,
// writeback FSM states and fault codes.
package core_pkg;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b000;
    localparam logic [2:0] OP_SH  = 3'b001;
    localparam logic [2:0] OP_SW  = 3'b010;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_MEM  = 1'b1
    } wb_state_e;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
    localparam logic [1:0] FAULT_MISALIGN = 2'b10;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a load word and sign- or
// zero-extends it according to funct3.
module load_align
    import core_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  raddr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (raddr)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = raddr[1] ? rdata[31:16] : rdata[15:0];

        // Undefined width codes fall through to the full word, like LW.
        case (funct3)
            OP_LB:   data = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  data = {24'b0, lane_b};
            OP_LH:   data = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  data = {16'b0, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback.sv
// Writeback stage: register-file writes, data-memory access with watchdog.
// Optional build macro WB_MISALIGN_TRAP_EN traps misaligned halfword/word accesses.
module writeback
    import core_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        wb_valid,
    input  logic [31:0] wb_result,
    input  logic        wb_memwr,
    input  logic        wb_mem2reg,
    input  logic        wb_alu2reg,
    input  logic [4:0]  wb_dst_sel,
    input  logic [1:0]  wb_raddr,
    input  logic [2:0]  wb_aluop,
    input  logic [31:0] wb_waddr,
    input  logic [3:0]  wb_wstrb,
    input  logic [31:0] wb_wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wb_stall,
    output logic        wb_fault,
    output logic [1:0]  wb_fault_code
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    wb_state_e   state, state_nxt;
    logic [7:0]  cnt;
    logic        m_we;
    logic [31:2] m_addr;
    logic [2:0]  m_funct3;
    logic [4:0]  m_rd;
    logic [1:0]  m_raddr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_wdata;
    logic [31:0] load_data;
    logic        is_mem;
    logic        misalign;
    logic        timeout_hit;

    assign is_mem      = wb_valid & (wb_memwr | wb_mem2reg);
    assign timeout_hit = (cnt == TO_LAST);

`ifdef WB_MISALIGN_TRAP_EN
    logic [1:0] cap_lo;
    logic       is_half;
    assign cap_lo   = wb_memwr ? wb_waddr[1:0] : wb_result[1:0];
    // LHU's code has no store counterpart, so it only counts for loads.
    assign is_half  = (wb_aluop == OP_LH) | (~wb_memwr & (wb_aluop == OP_LHU));
    assign misalign = (is_half & cap_lo[0]) | ((wb_aluop == OP_LW) & (cap_lo != 2'b00));
`else
    logic unused_addr_lo;
    assign unused_addr_lo = ^{wb_waddr[1:0], wb_result[1:0]};
    assign misalign       = 1'b0;
`endif

    load_align u_load_align (
        .funct3 (m_funct3),
        .raddr  (m_raddr),
        .rdata  (dmem_rdata),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (resetb) state <= WB_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE: if (is_mem && !misalign)         state_nxt = WB_MEM;
            WB_MEM:  if (dmem_ready || timeout_hit)   state_nxt = WB_IDLE;
            default:                                  state_nxt = WB_IDLE;
        endcase
    end

    // Request side is decoded from state so it drops the cycle after reset.
    always_comb begin
        dmem_req   = (state == WB_MEM);
        dmem_we    = dmem_req & m_we;
        dmem_addr  = dmem_req ? {m_addr, 2'b00} : 32'b0;
        dmem_wstrb = dmem_we ? m_wstrb : 4'b0;
        dmem_wdata = dmem_we ? m_wdata : 32'b0;
        wb_stall   = dmem_req;
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            cnt           <= 8'd0;
            m_we          <= 1'b0;
            m_addr        <= '0;
            m_funct3      <= 3'b0;
            m_rd          <= 5'b0;
            m_raddr       <= 2'b0;
            m_wstrb       <= 4'b0;
            m_wdata       <= 32'b0;
            rf_we         <= 1'b0;
            rf_waddr      <= 5'b0;
            rf_wdata      <= 32'b0;
            wb_fault      <= 1'b0;
            wb_fault_code <= FAULT_NONE;
        end else begin
            rf_we         <= 1'b0;
            wb_fault      <= 1'b0;
            wb_fault_code <= FAULT_NONE;
            if (state == WB_IDLE) begin
                cnt <= 8'd0;
                if (is_mem) begin
                    if (misalign) begin
                        wb_fault      <= 1'b1;
                        wb_fault_code <= FAULT_MISALIGN;
                    end else begin
                        m_we     <= wb_memwr;
                        m_addr   <= wb_memwr ? wb_waddr[31:2] : wb_result[31:2];
                        m_funct3 <= wb_aluop;
                        m_rd     <= wb_dst_sel;
                        m_raddr  <= wb_raddr;
                        m_wstrb  <= wb_memwr ? wb_wstrb : 4'b0;
                        m_wdata  <= wb_wdata;
                    end
                end else if (wb_valid) begin
                    rf_we    <= wb_alu2reg & (wb_dst_sel != 5'd0);
                    rf_waddr <= wb_dst_sel;
                    rf_wdata <= wb_result;
                end
            end else begin
                // A completion in the expiry cycle still counts as success.
                if (dmem_ready) begin
                    if (!m_we) begin
                        rf_we    <= (m_rd != 5'd0);
                        rf_waddr <= m_rd;
                        rf_wdata <= load_data;
                    end
                end else if (timeout_hit) begin
                    wb_fault      <= 1'b1;
                    wb_fault_code <= FAULT_TIMEOUT;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

endmodule
